// File: rtl/sata_link_ctrl.sv
// ---------------------------------------------------------------------------
// sata_link_ctrl
//
// Per-port SATA link bring-up sequencer. It sits between the AHCI port logic
// and one lane of the GTX/GTP PHY wrapper. It holds the lane in phyreset,
// fires the OOB StartComm pulse, times out and retries OOB, and reports an
// SStatus-style DET code together with link-OK status and link-change pulses.
//
// Parameters
//   C_RESET_CYCLES  cycles port_phyreset is held high in RESET (min 1)
//   C_LINK_TIMEOUT  cycles allowed from the StartComm pulse to linkup
//   C_RETRY_DELAY   backoff cycles before an OOB retry (min 1)
//   C_MAX_RETRY     consecutive timeouts before OFFLINE, 0 = retry forever
//
// Ports
//   phyclk         in   sole clock, rising edge
//   phyreset       in   asynchronous active-high reset
//   plllock        in   PHY PLL lock (asynchronous, synchronized here)
//   linkup         in   lane link up (phyclk domain)
//   CommInit       in   device answered COMINIT (phyclk domain)
//   comreset_req   in   one-cycle request to restart bring-up
//   port_disable   in   level, forces the port offline
//   port_phyreset  out  lane phyreset
//   StartComm      out  one-cycle OOB start pulse
//   det            out  0 none, 1 device w/o link, 3 link up, 4 offline
//   link_ok        out  high while the link is established
//   link_change    out  one-cycle pulse whenever link_ok changes
//   retry_cnt      out  consecutive OOB timeouts, saturating at 255
// ---------------------------------------------------------------------------
module sata_link_ctrl #(
    parameter int unsigned C_RESET_CYCLES = 64,
    parameter int unsigned C_LINK_TIMEOUT = 750000,
    parameter int unsigned C_RETRY_DELAY  = 75000,
    parameter int unsigned C_MAX_RETRY    = 0
) (
    input  logic       phyclk,
    input  logic       phyreset,
    input  logic       plllock,
    input  logic       linkup,
    input  logic       CommInit,
    input  logic       comreset_req,
    input  logic       port_disable,
    output logic       port_phyreset,
    output logic       StartComm,
    output logic [3:0] det,
    output logic       link_ok,
    output logic       link_change,
    output logic [7:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_COMM,
        S_WAIT_LINK,
        S_LINKED,
        S_BACKOFF,
        S_OFFLINE
    } state_t;

    localparam logic [3:0] DET_NONE    = 4'd0;
    localparam logic [3:0] DET_PRESENT = 4'd1;
    localparam logic [3:0] DET_LINK    = 4'd3;
    localparam logic [3:0] DET_OFFLINE = 4'd4;

    // The counter runs from load value down to 0, so a load of N-1 gives N cycles.
    localparam logic [23:0] RESET_LOAD   = 24'(C_RESET_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LOAD = 24'(C_LINK_TIMEOUT - 1);
    localparam logic [23:0] BACKOFF_LOAD = 24'(C_RETRY_DELAY - 1);

    state_t      state, next_state;
    logic [23:0] cnt, next_cnt;
    logic [7:0]  next_retry;
    logic [7:0]  retry_inc;
    logic [3:0]  next_det;
    logic        restart;
    logic        plllock_meta, plllock_sync;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge phyclk or posedge phyreset) begin
        if (phyreset) begin
            plllock_meta <= 1'b0;
            plllock_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep the two stages distinct flops.
            plllock_meta <= plllock;
            plllock_sync <= plllock_meta;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        next_state = state;
        next_cnt   = cnt;
        next_retry = retry_cnt;
        next_det   = DET_NONE;
        restart    = 1'b0;
        retry_inc  = (retry_cnt == 8'hFF) ? 8'hFF : retry_cnt + 8'd1;

        if (port_disable) begin
            next_state = S_OFFLINE;
        end else if (!plllock_sync && state != S_OFFLINE) begin
            next_state = S_IDLE;
        end else if (comreset_req && state != S_OFFLINE && state != S_IDLE) begin
            next_state = S_RESET;
            next_retry = 8'd0;
            restart    = 1'b1;
        end else begin
            case (state)
                S_IDLE:      next_state = S_RESET;
                S_RESET: begin
                    if (cnt == 24'd0) next_state = S_COMM;
                    else              next_cnt   = cnt - 24'd1;
                end
                S_COMM:      next_state = S_WAIT_LINK;
                S_WAIT_LINK: begin
                    // linkup beats a simultaneous timeout.
                    if (linkup) begin
                        next_state = S_LINKED;
                        next_retry = 8'd0;
                    end else if (cnt == 24'd0) begin
                        next_retry = retry_inc;
                        if (C_MAX_RETRY != 0 && {24'd0, retry_inc} >= C_MAX_RETRY)
                            next_state = S_OFFLINE;
                        else
                            next_state = S_BACKOFF;
                    end else begin
                        next_cnt = cnt - 24'd1;
                    end
                end
                S_LINKED: begin
                    if (!linkup) next_state = S_BACKOFF;
                end
                S_BACKOFF: begin
                    if (cnt == 24'd0) next_state = S_RESET;
                    else              next_cnt   = cnt - 24'd1;
                end
                S_OFFLINE: begin
                    if (comreset_req) next_state = S_IDLE;
                end
                default:     next_state = S_IDLE;
            endcase
        end

        // Load the shared counter on every state entry; a COMRESET while already
        // in RESET counts as a fresh entry and restarts the full hold time.
        if (next_state != state || restart) begin
            case (next_state)
                S_RESET:     next_cnt = RESET_LOAD;
                S_WAIT_LINK: next_cnt = TIMEOUT_LOAD;
                S_BACKOFF:   next_cnt = BACKOFF_LOAD;
                default:     next_cnt = 24'd0;
            endcase
        end

        // DET follows the state being entered; the "device present" code is
        // sticky for as long as WAIT_LINK lasts.
        case (next_state)
            S_WAIT_LINK: next_det = ((state == S_WAIT_LINK && det == DET_PRESENT) || CommInit)
                                    ? DET_PRESENT : DET_NONE;
            S_LINKED:    next_det = DET_LINK;
            S_OFFLINE:   next_det = DET_OFFLINE;
            default:     next_det = DET_NONE;
        endcase
    end

    // All outputs are registered from next_state so they change on the very
    // edge that enters the new state and can never glitch.
    always_ff @(posedge phyclk or posedge phyreset) begin
        if (phyreset) begin
            state         <= S_IDLE;
            cnt           <= 24'd0;
            port_phyreset <= 1'b1;
            StartComm     <= 1'b0;
            det           <= DET_NONE;
            link_ok       <= 1'b0;
            link_change   <= 1'b0;
            retry_cnt     <= 8'd0;
        end else begin
            state         <= next_state;
            cnt           <= next_cnt;
            port_phyreset <= (next_state == S_IDLE) || (next_state == S_RESET) ||
                             (next_state == S_OFFLINE);
            StartComm     <= (next_state == S_COMM);
            det           <= next_det;
            link_ok       <= (next_state == S_LINKED);
            link_change   <= (next_state == S_LINKED) != (state == S_LINKED);
            retry_cnt     <= next_retry;
        end
    end

endmodule

// File: tb/tb_sata_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sata_link_ctrl
//
// Scoreboard bench for sata_link_ctrl. Every time the stimulus thread drives
// an event it pushes the output vector it expects and the clock edge at which
// that vector must appear. A monitor samples the outputs on the falling edge;
// each time the output vector changes it pops the oldest expectation and
// compares both value and edge number.
//
// Output vector: {port_phyreset, StartComm, det[3:0], link_ok, link_change,
//                 retry_cnt[7:0]}
// ---------------------------------------------------------------------------
module tb_sata_link_ctrl;

    typedef struct {
        string       tag;
        logic [15:0] vec;
        int          cyc;
    } exp_t;

    logic       phyclk = 1'b0;
    logic       phyreset;
    logic       plllock;
    logic       linkup;
    logic       CommInit;
    logic       comreset_req;
    logic       port_disable;
    logic       port_phyreset;
    logic       StartComm;
    logic [3:0] det;
    logic       link_ok;
    logic       link_change;
    logic [7:0] retry_cnt;

    logic [15:0] out_vec;
    logic [15:0] prev_vec = 16'h8000;
    exp_t        sb[$];
    exp_t        cur_exp;
    int          cyc    = 0;
    int          checks = 0;
    int          fails  = 0;

    sata_link_ctrl #(
        .C_RESET_CYCLES(4),
        .C_LINK_TIMEOUT(100),
        .C_RETRY_DELAY (20),
        .C_MAX_RETRY   (3)
    ) dut (
        .phyclk       (phyclk),
        .phyreset     (phyreset),
        .plllock      (plllock),
        .linkup       (linkup),
        .CommInit     (CommInit),
        .comreset_req (comreset_req),
        .port_disable (port_disable),
        .port_phyreset(port_phyreset),
        .StartComm    (StartComm),
        .det          (det),
        .link_ok      (link_ok),
        .link_change  (link_change),
        .retry_cnt    (retry_cnt)
    );

    always #5 phyclk = ~phyclk;
    always @(posedge phyclk) cyc <= cyc + 1;

    assign out_vec = {port_phyreset, StartComm, det, link_ok, link_change, retry_cnt};

    function automatic logic [15:0] mk(logic ph, logic sc, logic [3:0] d, logic ok,
                                       logic chg, logic [7:0] rc);
        return {ph, sc, d, ok, chg, rc};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(string tag, logic [15:0] v, int c);
        sb.push_back('{tag: tag, vec: v, cyc: c});
    endtask

    task automatic tick();
        @(posedge phyclk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    // Monitor: any change of the output vector is a DUT "result".
    always @(negedge phyclk) begin
        if (out_vec !== prev_vec) begin
            if (sb.size() == 0) begin
                check("sb_extra_event", 32'(sb.size()), 32'd1);
            end else begin
                cur_exp = sb.pop_front();
                check(cur_exp.tag, 32'(out_vec), 32'(cur_exp.vec));
                check({cur_exp.tag, "_cyc"}, 32'(cyc), 32'(cur_exp.cyc));
            end
            prev_vec = out_vec;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, l, w, wi, o, w4, p, w5, q, r, w6, x;

        phyreset     = 1'b1;
        plllock      = 1'b0;
        linkup       = 1'b0;
        CommInit     = 1'b0;
        comreset_req = 1'b0;
        port_disable = 1'b0;
        repeat (3) tick();
        check("reset_vec", 32'(out_vec), 32'(mk(1, 0, 0, 0, 0, 0)));

        // Bring-up: 2 sync stages + 1 decision -> RESET, 4 cycles -> COMM.
        s = cyc + 7;
        push("bu_comm",     mk(0, 1, 0, 0, 0, 0), s);
        push("bu_wait",     mk(0, 0, 0, 0, 0, 0), s + 1);
        push("bu_linked",   mk(0, 0, 3, 1, 1, 0), s + 50);
        push("bu_chg_end",  mk(0, 0, 3, 1, 0, 0), s + 51);
        phyreset = 1'b0;
        plllock  = 1'b1;
        wait_until(s + 49);
        linkup = 1'b1;

        // Link loss: BACKOFF 20 cycles, then RESET 4, COMM, WAIT_LINK.
        l = s + 60;
        push("loss_drop",    mk(0, 0, 0, 0, 1, 0), l + 1);
        push("loss_chg_end", mk(0, 0, 0, 0, 0, 0), l + 2);
        push("loss_reset",   mk(1, 0, 0, 0, 0, 0), l + 21);
        push("loss_comm",    mk(0, 1, 0, 0, 0, 0), l + 25);
        push("loss_wait",    mk(0, 0, 0, 0, 0, 0), l + 26);
        wait_until(l);
        linkup = 1'b0;

        // Timeout/retry: one CommInit, three timeouts, OFFLINE on the third.
        w = l + 26;
        push("ci_det", mk(0, 0, 1, 0, 0, 0), w + 6);
        for (int i = 0; i < 3; i++) begin
            wi = w + 125 * i;
            if (i < 2) begin
                push($sformatf("to%0d_backoff", i + 1), mk(0, 0, 0, 0, 0, 8'(i + 1)), wi + 100);
                push($sformatf("to%0d_reset", i + 1),   mk(1, 0, 0, 0, 0, 8'(i + 1)), wi + 120);
                push($sformatf("to%0d_comm", i + 1),    mk(0, 1, 0, 0, 0, 8'(i + 1)), wi + 124);
                push($sformatf("to%0d_wait", i + 1),    mk(0, 0, 0, 0, 0, 8'(i + 1)), wi + 125);
            end else begin
                push("to3_offline", mk(1, 0, 4, 0, 0, 3), wi + 100);
            end
        end
        wait_until(w + 5);
        CommInit = 1'b1;
        tick();
        CommInit = 1'b0;

        // Leave OFFLINE with a COMRESET: IDLE, then RESET, COMM.
        o = w + 360;
        push("off_idle", mk(1, 0, 0, 0, 0, 3), o + 1);
        push("off_comm", mk(0, 1, 0, 0, 0, 3), o + 6);
        push("off_wait", mk(0, 0, 0, 0, 0, 3), o + 7);
        wait_until(o);
        comreset_req = 1'b1;
        tick();
        comreset_req = 1'b0;

        // port_disable beats comreset_req in WAIT_LINK.
        w4 = o + 7;
        push("dis_offline", mk(1, 0, 4, 0, 0, 3), w4 + 11);
        wait_until(w4 + 10);
        port_disable = 1'b1;
        comreset_req = 1'b1;
        tick();
        comreset_req = 1'b0;
        wait_until(w4 + 15);
        comreset_req = 1'b1;    // ignored while disabled
        tick();
        comreset_req = 1'b0;

        // Re-enable, then a second COMRESET during RESET restarts the hold and
        // clears retry_cnt.
        p = w4 + 20;
        push("en_idle",      mk(1, 0, 0, 0, 0, 3), p + 1);
        push("rst_restart",  mk(1, 0, 0, 0, 0, 0), p + 4);
        push("restart_comm", mk(0, 1, 0, 0, 0, 0), p + 8);
        push("restart_wait", mk(0, 0, 0, 0, 0, 0), p + 9);
        wait_until(p);
        port_disable = 1'b0;
        comreset_req = 1'b1;
        tick();
        comreset_req = 1'b0;
        wait_until(p + 3);
        comreset_req = 1'b1;
        tick();
        comreset_req = 1'b0;

        // PLL loss in LINKED: IDLE three cycles after plllock drops.
        w5 = p + 9;
        q  = w5 + 10;
        push("pll_linked",  mk(0, 0, 3, 1, 1, 0), w5 + 4);
        push("pll_chg_end", mk(0, 0, 3, 1, 0, 0), w5 + 5);
        push("pll_idle",    mk(1, 0, 0, 0, 1, 0), q + 3);
        push("pll_idle2",   mk(1, 0, 0, 0, 0, 0), q + 4);
        wait_until(w5 + 3);
        linkup = 1'b1;
        wait_until(q);
        plllock = 1'b0;
        wait_until(q + 3);
        linkup = 1'b0;

        // PLL back: RESET after 3, COMM after 4 more.
        r  = q + 5;
        w6 = r + 8;
        push("relock_comm", mk(0, 1, 0, 0, 0, 0), r + 7);
        push("relock_wait", mk(0, 0, 0, 0, 0, 0), w6);
        wait_until(r);
        plllock = 1'b1;

        // linkup in the expiry cycle wins over the timeout.
        push("race_linked",  mk(0, 0, 3, 1, 1, 0), w6 + 100);
        push("race_chg_end", mk(0, 0, 3, 1, 0, 0), w6 + 101);
        wait_until(w6 + 99);
        linkup = 1'b1;

        // comreset_req together with a linkup drop: RESET, link_change pulses.
        push("crl_reset",   mk(1, 0, 0, 0, 1, 0), w6 + 111);
        push("crl_chg_end", mk(1, 0, 0, 0, 0, 0), w6 + 112);
        push("crl_comm",    mk(0, 1, 0, 0, 0, 0), w6 + 115);
        push("arst_vec",    mk(1, 0, 0, 0, 0, 0), w6 + 116);
        wait_until(w6 + 110);
        linkup       = 1'b0;
        comreset_req = 1'b1;
        tick();
        comreset_req = 1'b0;

        // Asynchronous reset in the COMM cycle, after the monitor has seen it.
        wait_until(w6 + 115);
        #6;
        phyreset = 1'b1;
        #1;
        check("arst_now", 32'(out_vec), 32'(mk(1, 0, 0, 0, 0, 0)));
        repeat (3) tick();
        x = cyc;
        push("post_rst_comm", mk(0, 1, 0, 0, 0, 0), x + 7);
        push("post_rst_wait", mk(0, 0, 0, 0, 0, 0), x + 8);
        phyreset = 1'b0;
        wait_until(x + 20);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
